// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_pkg
//  Description : Shared definitions for the WS2812 chain driver: the frame
//                state encoding and an elaboration-time ceiling-log2 helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BIT   = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // Number of bits needed to index 'value' distinct items (clog2(1) = 0).
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_scale.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_scale
//  Description : Combinational global-brightness scaler. Every 8-bit channel
//                of a pixel is scaled as (ch * (brightness + 1)) >> 8, so a
//                brightness of 255 is transparent and 0 blanks the pixel.
//  Ports       : i_pixel  [COLOR_BITS] raw pixel, channels packed MSB first
//                i_bright [8]          global brightness
//                o_pixel  [COLOR_BITS] scaled pixel
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_scale
    import ws2812_pkg::*;
#(
    parameter int COLOR_BITS = 24
) (
    input  logic [COLOR_BITS-1:0] i_pixel,
    input  logic [7:0]            i_bright,
    output logic [COLOR_BITS-1:0] o_pixel
);

    localparam int c_CHANNELS = COLOR_BITS / 8;

    logic [8:0] w_factor;

    // brightness + 1 needs nine bits so that 255 becomes a factor of 256.
    assign w_factor = {1'b0, i_bright} + 9'd1;

    for (genvar g = 0; g < c_CHANNELS; g++) begin : g_chan
        // 255 * 256 = 65280 still fits in 16 bits.
        logic [15:0] w_prod;
        assign w_prod               = i_pixel[g*8 +: 8] * w_factor;
        assign o_pixel[g*8 +: 8]    = w_prod[15:8];
    end

endmodule
`default_nettype wire

// File: rtl/ws2812_chain.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_chain
//  Description : WS2812 / SK6812 chain driver. Holds a pixel memory written
//                over a simple strobe port and, on request (or continuously
//                when AUTO_REFRESH=1), streams every pixel scaled by a frame-
//                latched brightness onto a single-wire NRZ line, followed by
//                a latch (reset) low period.
//  Ports       : clk         sole clock
//                rst_n       asynchronous active-low reset
//                wr_en       pixel write strobe
//                wr_addr     pixel index (writes at >= NUM_LEDS ignored)
//                wr_data     pixel colour, channels MSB first
//                brightness  global scale, sampled at frame start
//                start       frame request pulse (ignored while busy)
//                busy        frame in progress
//                frame_done  one-cycle pulse at the end of a frame
//                data_out    serial LED line
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_chain
    import ws2812_pkg::*;
#(
    parameter int CLK_MHZ      = 27,
    parameter int NUM_LEDS     = 8,
    parameter int COLOR_BITS   = 24,
    parameter int T_ON_NS      = 850,
    parameter int T_OFF_NS     = 450,
    parameter int T_PERIOD_NS  = 1250,
    parameter int T_RESET_US   = 280,
    parameter int AUTO_REFRESH = 0,
    localparam int ADDR_W      = (NUM_LEDS > 1) ? clog2(NUM_LEDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [COLOR_BITS-1:0] wr_data,
    input  logic [7:0]            brightness,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  data_out
);

    // ------------------------------------------------------------------
    // Timing constants in clock cycles
    // ------------------------------------------------------------------
    localparam int c_T_PERIOD = CLK_MHZ * T_PERIOD_NS / 1000;
    localparam int c_T_ON     = CLK_MHZ * T_ON_NS / 1000;
    localparam int c_T_OFF    = CLK_MHZ * T_OFF_NS / 1000;
    localparam int c_T_RESET  = CLK_MHZ * T_RESET_US;
    localparam int c_CNT_MAX  = (c_T_RESET > c_T_PERIOD) ? c_T_RESET : c_T_PERIOD;
    localparam int c_CNT_W    = clog2(c_CNT_MAX + 1);
    localparam int c_BIT_W    = clog2(COLOR_BITS);

    localparam logic [c_CNT_W-1:0] c_PERIOD_END = c_CNT_W'(c_T_PERIOD - 1);
    localparam logic [c_CNT_W-1:0] c_LOAD_AT    = c_CNT_W'(c_T_PERIOD - 2);
    localparam logic [c_CNT_W-1:0] c_LATCH_END  = c_CNT_W'(c_T_RESET - 1);
    localparam logic [c_CNT_W-1:0] c_ON_CYC     = c_CNT_W'(c_T_ON);
    localparam logic [c_CNT_W-1:0] c_OFF_CYC    = c_CNT_W'(c_T_OFF);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT   = c_BIT_W'(COLOR_BITS - 1);
    localparam logic [ADDR_W-1:0]  c_LAST_PIX   = ADDR_W'(NUM_LEDS - 1);
    localparam logic [ADDR_W:0]    c_NUM_LEDS   = (ADDR_W + 1)'(NUM_LEDS);

    if (!(c_T_OFF > 0 && c_T_OFF < c_T_ON && c_T_ON < c_T_PERIOD)) begin : g_timing_check
        $error("ws2812_chain: bit timing must satisfy 0 < T_OFF < T_ON < T_PERIOD");
    end

    if (NUM_LEDS < 1 || NUM_LEDS > 256) begin : g_leds_check
        $error("ws2812_chain: NUM_LEDS must be in 1..256");
    end

    if (COLOR_BITS != 24 && COLOR_BITS != 32) begin : g_color_check
        $error("ws2812_chain: COLOR_BITS must be 24 or 32");
    end

    // ------------------------------------------------------------------
    // Pixel memory (no reset; contents undefined after power-up)
    // ------------------------------------------------------------------
    logic [COLOR_BITS-1:0] r_mem [0:NUM_LEDS-1];
    logic                  w_addr_ok;

    assign w_addr_ok = ({1'b0, wr_addr} < c_NUM_LEDS);

    always_ff @(posedge clk) begin
        if (wr_en && w_addr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [ADDR_W-1:0]     r_idx;
    logic [c_CNT_W-1:0]    r_cyc;
    logic [c_BIT_W-1:0]    r_bitn;
    logic [COLOR_BITS-1:0] r_shift;
    logic [7:0]            r_bright;
    logic                  r_dout;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_sent;

    logic [COLOR_BITS-1:0] w_pixel;
    logic [COLOR_BITS-1:0] w_scaled;
    logic [c_CNT_W-1:0]    w_cyc_next;
    logic [c_CNT_W-1:0]    w_thr;
    logic                  w_last_bit;
    logic                  w_last_pix;

    assign w_pixel    = r_mem[r_idx];
    assign w_cyc_next = r_cyc + 1'b1;
    assign w_thr      = r_shift[COLOR_BITS-1] ? c_ON_CYC : c_OFF_CYC;
    assign w_last_bit = (r_bitn == c_LAST_BIT);
    assign w_last_pix = (r_idx == c_LAST_PIX);

    ws2812_scale #(
        .COLOR_BITS (COLOR_BITS)
    ) u_scale (
        .i_pixel  (w_pixel),
        .i_bright (r_bright),
        .o_pixel  (w_scaled)
    );

    // data_out is registered: each branch computes the line level for the
    // cycle that follows, so the registered value lines up with r_cyc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // With auto refresh a full latch period runs before the first frame.
            r_state      <= (AUTO_REFRESH != 0) ? ST_LATCH : ST_IDLE;
            r_idx        <= '0;
            r_cyc        <= '0;
            r_bitn       <= '0;
            r_shift      <= '0;
            r_bright     <= '0;
            r_dout       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_sent       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_dout <= 1'b0;
                    if (start) begin
                        r_state  <= ST_LOAD;
                        r_bright <= brightness;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    r_shift <= w_scaled;
                    r_bitn  <= '0;
                    r_cyc   <= '0;
                    r_dout  <= 1'b1;  // every bit starts with a high phase
                    r_sent  <= 1'b1;
                    r_state <= ST_BIT;
                end

                ST_BIT: begin
                    if (w_last_bit && !w_last_pix && (r_cyc == c_LOAD_AT)) begin
                        // The LOAD cycle stands in for the final low cycle of
                        // this bit, keeping the stream gapless across pixels.
                        r_state <= ST_LOAD;
                        r_idx   <= r_idx + 1'b1;
                        r_dout  <= 1'b0;
                    end else if (r_cyc == c_PERIOD_END) begin
                        r_cyc <= '0;
                        if (w_last_bit) begin
                            r_state <= ST_LATCH;
                            r_dout  <= 1'b0;
                        end else begin
                            r_bitn  <= r_bitn + 1'b1;
                            r_shift <= {r_shift[COLOR_BITS-2:0], 1'b0};
                            r_dout  <= 1'b1;
                        end
                    end else begin
                        r_cyc  <= w_cyc_next;
                        r_dout <= (w_cyc_next < w_thr);
                    end
                end

                ST_LATCH: begin
                    r_dout <= 1'b0;
                    if (r_cyc == c_LATCH_END) begin
                        r_cyc        <= '0;
                        // The post-reset latch carries no frame, so no pulse.
                        r_frame_done <= r_sent;
                        r_sent       <= 1'b0;
                        if (AUTO_REFRESH != 0) begin
                            r_state  <= ST_LOAD;
                            r_idx    <= '0;
                            r_bright <= brightness;
                            r_busy   <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cyc <= w_cyc_next;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_dout  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign data_out   = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws2812_chain
//  Description : Directed bench for ws2812_chain at 10 MHz (T_PERIOD=12,
//                T_ON=8, T_OFF=4, T_RESET=2800). Instance A: 3 GRBW pixels,
//                single-shot frames. Instance B: 1 GRB pixel, auto refresh.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A
    logic        a_rst_n, a_wr_en, a_start;
    logic [1:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic [7:0]  a_bright;
    logic        a_busy, a_fd, a_dout;

    // Instance B
    logic        b_rst_n, b_wr_en, b_start;
    logic [0:0]  b_wr_addr;
    logic [23:0] b_wr_data;
    logic [7:0]  b_bright;
    logic        b_busy, b_fd, b_dout;

    ws2812_chain #(
        .CLK_MHZ(10), .NUM_LEDS(3), .COLOR_BITS(32), .T_ON_NS(850), .T_OFF_NS(450),
        .T_PERIOD_NS(1250), .T_RESET_US(280), .AUTO_REFRESH(0)
    ) u_dut_a (
        .clk(clk), .rst_n(a_rst_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .brightness(a_bright), .start(a_start),
        .busy(a_busy), .frame_done(a_fd), .data_out(a_dout)
    );

    ws2812_chain #(
        .CLK_MHZ(10), .NUM_LEDS(1), .COLOR_BITS(24), .T_ON_NS(850), .T_OFF_NS(450),
        .T_PERIOD_NS(1250), .T_RESET_US(280), .AUTO_REFRESH(1)
    ) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .brightness(b_bright), .start(b_start),
        .busy(b_busy), .frame_done(b_fd), .data_out(b_dout)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic a_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        a_wr_en   = 1'b1;
        a_wr_addr = addr;
        a_wr_data = data;
        @(negedge clk);
        a_wr_en   = 1'b0;
    endtask

    task automatic a_pulse_start();
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    // Decodes nbits from the selected line (sampled on falling edges).
    // Counts periods other than 12 cycles, high widths other than 4/8, and
    // the low time after the final high phase up to the frame_done pulse.
    task automatic capture(input bit sel, input int nbits, output logic [95:0] bits,
                           output int bad_period, output int bad_width, output int tail);
        int hi;
        int lo;
        int guard;
        bits = '0; bad_period = 0; bad_width = 0; tail = 0; guard = 0;
        while ((sel ? b_dout : a_dout) !== 1'b1 && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) bad_width = 1000;
        for (int b = 0; b < nbits; b++) begin
            hi = 0;
            while ((sel ? b_dout : a_dout) === 1'b1 && hi < 50) begin
                hi++;
                @(negedge clk);
            end
            lo = 0;
            if (b < nbits - 1) begin
                while ((sel ? b_dout : a_dout) === 1'b0 && lo < 50) begin
                    lo++;
                    @(negedge clk);
                end
                if (hi + lo != 12) bad_period++;
            end else begin
                while ((sel ? b_dout : a_dout) === 1'b0 && (sel ? b_fd : a_fd) !== 1'b1
                       && lo < 5000) begin
                    lo++;
                    @(negedge clk);
                end
                tail = lo;
            end
            if (hi == 8)      bits = {bits[94:0], 1'b1};
            else if (hi == 4) bits = {bits[94:0], 1'b0};
            else              bad_width++;
        end
    endtask

    initial begin
        logic [95:0] bits;
        int bp, bw, tail, n, seen;

        a_rst_n = 1'b0; a_wr_en = 1'b0; a_start = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        a_bright = 8'd255;
        b_rst_n = 1'b0; b_wr_en = 1'b0; b_start = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        b_bright = 8'd255;
        repeat (3) @(negedge clk);

        check("rst_dout", 128'(a_dout), 128'(1'b0));
        check("rst_busy", 128'(a_busy), 128'(1'b0));
        check("rst_fd",   128'(a_fd),   128'(1'b0));
        a_rst_n = 1'b1;

        // Frame 1: full brightness, three distinct pixels
        a_write(2'd0, 32'hFF00_0000);
        a_write(2'd1, 32'h8000_00FF);
        a_write(2'd2, 32'h0FF0_55AA);
        a_pulse_start();
        check("f1_busy", 128'(a_busy), 128'(1'b1));
        capture(1'b0, 96, bits, bp, bw, tail);
        check("f1_bits",   128'(bits), 128'({32'hFF00_0000, 32'h8000_00FF, 32'h0FF0_55AA}));
        check("f1_period", 128'(bp),   128'(0));
        check("f1_width",  128'(bw),   128'(0));
        check("f1_tail",   128'(tail), 128'(2808));
        check("f1_fd",     128'(a_fd), 128'(1'b1));
        @(negedge clk);
        check("f1_fd_one", 128'(a_fd),   128'(1'b0));
        check("f1_idle",   128'(a_busy), 128'(1'b0));

        // Frame 2: brightness 127; mid-frame start, brightness and writes
        a_write(2'd0, 32'h80FF_0001);
        a_write(2'd1, 32'h0000_0000);
        a_write(2'd2, 32'h0000_0000);
        a_bright = 8'd127;
        a_pulse_start();
        fork
            capture(1'b0, 96, bits, bp, bw, tail);
            begin
                repeat (60) @(negedge clk);
                a_start = 1'b1;
                @(negedge clk);
                a_start  = 1'b0;
                a_bright = 8'd255;
                a_write(2'd0, 32'hFFFF_FFFF);
                a_write(2'd2, 32'h0210_FEC8);
            end
        join
        check("f2_bits",   128'(bits), 128'({32'h407F_0000, 32'h0000_0000, 32'h0108_7F64}));
        check("f2_period", 128'(bp),   128'(0));
        check("f2_width",  128'(bw),   128'(0));
        check("f2_tail",   128'(tail), 128'(2808));
        check("f2_fd",     128'(a_fd), 128'(1'b1));
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_busy === 1'b1 || a_fd === 1'b1) seen++;
        end
        check("f2_no_queue", 128'(seen), 128'(0));

        // Frame 3: new pixel 0 and brightness 255 now take effect
        a_pulse_start();
        capture(1'b0, 96, bits, bp, bw, tail);
        check("f3_bits",   128'(bits), 128'({32'hFFFF_FFFF, 32'h0000_0000, 32'h0210_FEC8}));
        check("f3_period", 128'(bp),   128'(0));
        check("f3_tail",   128'(tail), 128'(2808));

        // Frame 4: aborted by reset while the line is high
        repeat (5) @(negedge clk);
        a_pulse_start();
        n = 0;
        while (a_dout !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        repeat (30) @(negedge clk);
        while (a_dout !== 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("f4_high_seen", 128'(a_dout), 128'(1'b1));
        #1 a_rst_n = 1'b0;
        #1;
        check("abort_dout", 128'(a_dout), 128'(1'b0));
        check("abort_busy", 128'(a_busy), 128'(1'b0));
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (a_fd === 1'b1) seen++;
        end
        a_rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (a_fd === 1'b1) seen++;
        end
        check("abort_no_fd", 128'(seen), 128'(0));

        // Frame 5: memory survives reset
        a_pulse_start();
        capture(1'b0, 96, bits, bp, bw, tail);
        check("f5_bits",   128'(bits), 128'({32'hFFFF_FFFF, 32'h0000_0000, 32'h0210_FEC8}));
        check("f5_period", 128'(bp),   128'(0));

        // Instance B: auto refresh, single GRB pixel
        @(negedge clk);
        b_wr_en   = 1'b1;
        b_wr_addr = 1'b0;
        b_wr_data = 24'hFF_0000;
        @(negedge clk);
        b_wr_en = 1'b0;
        b_rst_n = 1'b1;
        n = 0;
        @(negedge clk);
        while (b_dout === 1'b0 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check("b_first_latch", 128'(n), 128'(2800));
        capture(1'b1, 24, bits, bp, bw, tail);
        check("b1_bits",   128'(bits), 128'(24'hFF_0000));
        check("b1_period", 128'(bp),   128'(0));
        check("b1_width",  128'(bw),   128'(0));
        check("b1_tail",   128'(tail), 128'(2808));
        check("b1_fd",     128'(b_fd), 128'(1'b1));
        @(negedge clk);
        check("b_repeat_dout", 128'(b_dout), 128'(1'b1));
        check("b_repeat_busy", 128'(b_busy), 128'(1'b1));
        capture(1'b1, 24, bits, bp, bw, tail);
        check("b2_bits", 128'(bits), 128'(24'hFF_0000));
        check("b2_tail", 128'(tail), 128'(2808));
        check("b2_fd",   128'(b_fd), 128'(1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
